// File: rtl/ps2_host_ctrl.sv
// PS/2 host command sequencer: keyboard reset / LED update sequences,
// host-to-device frame transmitter on open-drain enables, and masking of
// the response bytes from the key decoder while a sequence is in flight.
module ps2_host_ctrl #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int ACK_TIMEOUT    = 750000,
    parameter int BAT_TIMEOUT    = 37500000,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk50m,
    input  logic       reset_n,
    input  logic       kbd_clk_in,
    input  logic       kbd_data_in,
    output logic       kbd_clk_oe,
    output logic       kbd_data_oe,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic [2:0] leds,
    input  logic       led_update,
    input  logic       kb_reset_req,
    output logic       busy,
    output logic       kb_ready,
    output logic       err,
    output logic       rx_mask
);
    localparam logic [31:0] INH_LAST  = 32'(INHIBIT_CYCLES - 1);
    localparam logic [31:0] ACK_LAST  = 32'(ACK_TIMEOUT - 1);
    localparam logic [31:0] BAT_LAST  = 32'(BAT_TIMEOUT - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

    localparam logic [2:0] TX_IDLE    = 3'd0;
    localparam logic [2:0] TX_INHIBIT = 3'd1;
    localparam logic [2:0] TX_START   = 3'd2;
    localparam logic [2:0] TX_SHIFT   = 3'd3;
    localparam logic [2:0] TX_ACK     = 3'd4;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SEND      = 3'd1;
    localparam logic [2:0] S_WAIT_RESP = 3'd2;
    localparam logic [2:0] S_WAIT_BAT  = 3'd3;
    localparam logic [2:0] S_ERROR     = 3'd4;

    // ---------------- line synchronisers ----------------
    logic [1:0] clk_sync_q, clk_sync_d;
    logic [1:0] data_sync_q, data_sync_d;
    logic       clk_prev_q, clk_prev_d;
    logic       clk_fall;

    // Two-stage synchronisers plus a delayed copy of the clock for edge detect
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], kbd_clk_in};
        data_sync_d = {data_sync_q[0], kbd_data_in};
        clk_prev_d  = clk_sync_q[1];
    end

    // Idle PS/2 lines are high, so the synchronisers reset to 1
    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

    assign clk_fall = clk_prev_q & ~clk_sync_q[1];

    // ---------------- command sequencer state (declared for the TX engine) ----
    logic [2:0]  state_q, state_d;
    logic [7:0]  cmd_byte_q, cmd_byte_d;
    logic        tx_go;

    // ---------------- TX engine ----------------
    logic [2:0]  tx_state_q, tx_state_d;
    logic [31:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [9:0]  sh_q, sh_d;
    logic        data_oe_q, data_oe_d;
    logic        tx_done, tx_ferr;

    // Frame transmitter: inhibit, start bit, 8 data + odd parity + stop, ACK.
    // tx_cnt is the inhibit counter, then restarts as the frame timeout.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sh_d       = sh_q;
        data_oe_d  = data_oe_q;
        tx_done    = 1'b0;
        tx_ferr    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                data_oe_d = 1'b0;
                if (tx_go) begin
                    tx_state_d = TX_INHIBIT;
                    tx_cnt_d   = '0;
                    bit_cnt_d  = '0;
                    sh_d       = {1'b1, ~^cmd_byte_q, cmd_byte_q};
                end
            end
            TX_INHIBIT: begin
                if (tx_cnt_q == INH_LAST) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    data_oe_d  = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 32'd1;
                end
            end
            TX_START, TX_SHIFT, TX_ACK: begin
                tx_cnt_d = tx_cnt_q + 32'd1;
                if (tx_cnt_q == ACK_LAST) begin
                    tx_state_d = TX_IDLE;
                    data_oe_d  = 1'b0;
                    tx_ferr    = 1'b1;
                end else if (clk_fall) begin
                    if (tx_state_q == TX_ACK) begin
                        tx_state_d = TX_IDLE;
                        tx_done    = ~data_sync_q[1];
                        tx_ferr    = data_sync_q[1];
                    end else begin
                        // Ten falling edges drive d0..d7, parity, stop
                        data_oe_d  = ~sh_q[0];
                        sh_d       = {1'b0, sh_q[9:1]};
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                        tx_state_d = (bit_cnt_q == 4'd9) ? TX_ACK : TX_SHIFT;
                    end
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                data_oe_d  = 1'b0;
            end
        endcase
    end

    // TX engine registers; reset releases both lines immediately
    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            sh_q       <= '0;
            data_oe_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
            data_oe_q  <= data_oe_d;
        end
    end

    assign kbd_clk_oe  = (tx_state_q == TX_INHIBIT);
    assign kbd_data_oe = data_oe_q;

    // ---------------- command sequencer ----------------
    logic        seq_led_q, seq_led_d;   // 0 = reset sequence, 1 = LED sequence
    logic        step_q, step_d;         // LED sequence: 0 = 0xED, 1 = LED byte
    logic [7:0]  retry_q, retry_d;
    logic        launched_q, launched_d;
    logic [31:0] tmr_q, tmr_d;
    logic        rst_pend_q, rst_pend_d;
    logic        led_pend_q, led_pend_d;
    logic        boot_q, boot_d;         // auto-run reset sequence after reset
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic        resend, fail;

    // Sequence control, request latching, retry and error handling
    always_comb begin
        state_d    = state_q;
        cmd_byte_d = cmd_byte_q;
        seq_led_d  = seq_led_q;
        step_d     = step_q;
        retry_d    = retry_q;
        launched_d = launched_q;
        tmr_d      = tmr_q;
        rst_pend_d = rst_pend_q | kb_reset_req;
        led_pend_d = led_pend_q | led_update;
        boot_d     = boot_q;
        ready_d    = ready_q;
        err_d      = err_q;
        tx_go      = 1'b0;
        resend     = 1'b0;
        fail       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (boot_q || rst_pend_q || kb_reset_req) begin
                    boot_d     = 1'b0;
                    rst_pend_d = 1'b0;
                    ready_d    = 1'b0;
                    err_d      = 1'b0;
                    seq_led_d  = 1'b0;
                    step_d     = 1'b0;
                    retry_d    = '0;
                    launched_d = 1'b0;
                    cmd_byte_d = 8'hFF;
                    state_d    = S_SEND;
                end else if (led_pend_q || led_update) begin
                    led_pend_d = 1'b0;
                    err_d      = 1'b0;
                    seq_led_d  = 1'b1;
                    step_d     = 1'b0;
                    retry_d    = '0;
                    launched_d = 1'b0;
                    cmd_byte_d = 8'hED;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                if (!launched_q) begin
                    tx_go      = 1'b1;
                    launched_d = 1'b1;
                end else if (tx_done) begin
                    launched_d = 1'b0;
                    tmr_d      = '0;
                    state_d    = S_WAIT_RESP;
                end else if (tx_ferr) begin
                    resend = 1'b1;
                end
            end
            S_WAIT_RESP: begin
                tmr_d = tmr_q + 32'd1;
                if (rx_valid && rx_byte == 8'hFA) begin
                    retry_d    = '0;
                    launched_d = 1'b0;
                    tmr_d      = '0;
                    if (!seq_led_q) begin
                        state_d = S_WAIT_BAT;
                    end else if (!step_q) begin
                        step_d     = 1'b1;
                        cmd_byte_d = {5'b0, leds};
                        state_d    = S_SEND;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if ((rx_valid && rx_byte == 8'hFE) || tmr_q == ACK_LAST) begin
                    resend = 1'b1;
                end
            end
            S_WAIT_BAT: begin
                tmr_d = tmr_q + 32'd1;
                if (rx_valid) begin
                    if (rx_byte == 8'hAA) begin
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (tmr_q == BAT_LAST) begin
                    fail = 1'b1;
                end
            end
            S_ERROR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Same byte goes out again until the retry budget is spent
        if (resend) begin
            launched_d = 1'b0;
            if (retry_q >= RETRY_MAX) begin
                fail = 1'b1;
            end else begin
                retry_d = retry_q + 8'd1;
                state_d = S_SEND;
            end
        end

        // A failed reset sequence also drops any LED update queued behind it
        if (fail) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            ready_d = 1'b0;
            if (!seq_led_q) begin
                led_pend_d = 1'b0;
            end
        end
    end

    // Sequencer registers; boot flag starts the reset sequence after reset
    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cmd_byte_q <= '0;
            seq_led_q  <= 1'b0;
            step_q     <= 1'b0;
            retry_q    <= '0;
            launched_q <= 1'b0;
            tmr_q      <= '0;
            rst_pend_q <= 1'b0;
            led_pend_q <= 1'b0;
            boot_q     <= 1'b1;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_byte_q <= cmd_byte_d;
            seq_led_q  <= seq_led_d;
            step_q     <= step_d;
            retry_q    <= retry_d;
            launched_q <= launched_d;
            tmr_q      <= tmr_d;
            rst_pend_q <= rst_pend_d;
            led_pend_q <= led_pend_d;
            boot_q     <= boot_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    assign busy     = (state_q == S_SEND) || (state_q == S_WAIT_RESP) || (state_q == S_WAIT_BAT);
    assign rx_mask  = (state_q == S_WAIT_RESP) || (state_q == S_WAIT_BAT);
    assign kb_ready = ready_q && (state_q == S_IDLE);
    assign err      = err_q;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Bench for ps2_host_ctrl: a behavioural keyboard clocks host frames in,
// ACKs them, and feeds response bytes through the receiver strobe.
module tb_ps2_host_ctrl;
    localparam int INH  = 20;
    localparam int ACKT = 300;
    localparam int BATT = 1000;
    localparam int MAXR = 3;

    logic       clk50m = 1'b0;
    logic       reset_n = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       kbd_clk_in, kbd_data_in, kbd_clk_oe, kbd_data_oe;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic [2:0] leds = 3'b000;
    logic       led_update = 1'b0;
    logic       kb_reset_req = 1'b0;
    logic       busy, kb_ready, err, rx_mask;
    int         n_chk = 0;
    int         n_fail = 0;

    // Open-drain wired-AND of host and device pull-downs
    assign kbd_clk_in  = ~(kbd_clk_oe | dev_clk_low);
    assign kbd_data_in = ~(kbd_data_oe | dev_data_low);

    always #10 clk50m = ~clk50m;

    ps2_host_ctrl #(
        .INHIBIT_CYCLES(INH),
        .ACK_TIMEOUT   (ACKT),
        .BAT_TIMEOUT   (BATT),
        .MAX_RETRY     (MAXR)
    ) dut (
        .clk50m      (clk50m),
        .reset_n     (reset_n),
        .kbd_clk_in  (kbd_clk_in),
        .kbd_data_in (kbd_data_in),
        .kbd_clk_oe  (kbd_clk_oe),
        .kbd_data_oe (kbd_data_oe),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .leds        (leds),
        .led_update  (led_update),
        .kb_reset_req(kb_reset_req),
        .busy        (busy),
        .kb_ready    (kb_ready),
        .err         (err),
        .rx_mask     (rx_mask)
    );

    typedef struct packed {
        logic [2:0] req;       // leds when led_update is pulsed
        logic [2:0] load;      // leds when the 0xFA to 0xED arrives
        logic [7:0] exp_byte;
        logic       exp_par;
    } led_vec_t;

    led_vec_t vecs [5];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Device side of one host-to-device frame; inh/hold = -1 if never seen
    task automatic dev_frame(input bit clock_it, output logic [7:0] b, output logic par,
                             output logic stp, output logic start, output int inh, output int hold);
        logic [9:0] bits;
        int t;
        b = '0; par = 1'b0; stp = 1'b0; start = 1'b1; inh = -1; hold = -1; bits = '0;
        t = 0;
        while (!kbd_clk_oe && t < 2000) begin @(negedge clk50m); t++; end
        if (!kbd_clk_oe) return;
        inh = 0;
        while (kbd_clk_oe && inh < 5000) begin @(negedge clk50m); inh++; end
        start = kbd_data_in;
        if (!clock_it) begin
            hold = 0;
            while (kbd_data_oe && hold < 5000) begin @(negedge clk50m); hold++; end
            return;
        end
        repeat (4) @(negedge clk50m);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1; repeat (8) @(negedge clk50m);
            bits[i] = kbd_data_in;
            dev_clk_low = 1'b0; repeat (8) @(negedge clk50m);
        end
        dev_data_low = 1'b1; repeat (2) @(negedge clk50m);
        dev_clk_low = 1'b1;  repeat (8) @(negedge clk50m);
        dev_clk_low = 1'b0; dev_data_low = 1'b0;
        repeat (4) @(negedge clk50m);
        b = bits[7:0]; par = bits[8]; stp = bits[9];
    endtask

    task automatic expect_frame(input string nm, input logic [7:0] eb, input logic ep);
        logic [7:0] b;
        logic p, s, st;
        int inh, hold;
        dev_frame(1'b1, b, p, s, st, inh, hold);
        chk({nm, " inhibit"}, inh, INH);
        chk({nm, " start"}, int'(st), 0);
        chk({nm, " byte"}, int'(b), int'(eb));
        chk({nm, " parity"}, int'(p), int'(ep));
        chk({nm, " stop"}, int'(s), 1);
    endtask

    task automatic ack_resp(input string nm, input logic [7:0] v);
        chk({nm, " rx_mask"}, int'(rx_mask), 1);
        rx_byte = v; rx_valid = 1'b1;
        @(negedge clk50m);
        rx_valid = 1'b0;
        @(negedge clk50m);
    endtask

    task automatic pulse_led();
        led_update = 1'b1; @(negedge clk50m); led_update = 1'b0;
    endtask

    task automatic pulse_rst();
        kb_reset_req = 1'b1; @(negedge clk50m); kb_reset_req = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while (busy && t < 3000) begin @(negedge clk50m); t++; end
        chk({nm, " idle"}, int'(busy), 0);
    endtask

    task automatic run_reset(input string nm);
        pulse_rst();
        expect_frame({nm, " FF"}, 8'hFF, 1'b1);
        ack_resp({nm, " FA"}, 8'hFA);
        ack_resp({nm, " AA"}, 8'hAA);
        chk({nm, " kb_ready"}, int'(kb_ready), 1);
        chk({nm, " err"}, int'(err), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic p, s, st;
        int inh, hold, seen;

        vecs[0] = '{req: 3'b101, load: 3'b101, exp_byte: 8'h05, exp_par: 1'b1};
        vecs[1] = '{req: 3'b000, load: 3'b000, exp_byte: 8'h00, exp_par: 1'b1};
        vecs[2] = '{req: 3'b111, load: 3'b111, exp_byte: 8'h07, exp_par: 1'b0};
        vecs[3] = '{req: 3'b001, load: 3'b110, exp_byte: 8'h06, exp_par: 1'b1};
        vecs[4] = '{req: 3'b010, load: 3'b010, exp_byte: 8'h02, exp_par: 1'b0};

        // Reset state
        repeat (3) @(negedge clk50m);
        chk("rst busy", int'(busy), 0);
        chk("rst kb_ready", int'(kb_ready), 0);
        chk("rst err", int'(err), 0);
        chk("rst rx_mask", int'(rx_mask), 0);
        chk("rst clk_oe", int'(kbd_clk_oe), 0);
        chk("rst data_oe", int'(kbd_data_oe), 0);

        // Power-up reset sequence
        reset_n = 1'b1;
        expect_frame("pwr FF", 8'hFF, 1'b1);
        chk("pwr busy", int'(busy), 1);
        ack_resp("pwr FA", 8'hFA);
        ack_resp("pwr AA", 8'hAA);
        chk("pwr kb_ready", int'(kb_ready), 1);
        chk("pwr err", int'(err), 0);
        chk("pwr busy done", int'(busy), 0);

        // LED update vectors
        for (int i = 0; i < 5; i++) begin
            leds = vecs[i].req;
            pulse_led();
            expect_frame($sformatf("led%0d ED", i), 8'hED, 1'b1);
            leds = vecs[i].load;
            ack_resp($sformatf("led%0d FA1", i), 8'hFA);
            expect_frame($sformatf("led%0d val", i), vecs[i].exp_byte, vecs[i].exp_par);
            ack_resp($sformatf("led%0d FA2", i), 8'hFA);
            chk($sformatf("led%0d busy", i), int'(busy), 0);
            chk($sformatf("led%0d kb_ready", i), int'(kb_ready), 1);
            chk($sformatf("led%0d err", i), int'(err), 0);
        end

        // Two resends then success
        leds = 3'b011;
        pulse_led();
        expect_frame("rs ED1", 8'hED, 1'b1);
        ack_resp("rs FE1", 8'hFE);
        expect_frame("rs ED2", 8'hED, 1'b1);
        ack_resp("rs FE2", 8'hFE);
        expect_frame("rs ED3", 8'hED, 1'b1);
        ack_resp("rs FA1", 8'hFA);
        expect_frame("rs val", 8'h03, 1'b1);
        ack_resp("rs FA2", 8'hFA);
        chk("rs err", int'(err), 0);
        chk("rs kb_ready", int'(kb_ready), 1);

        // Four resends exhaust the retry budget
        pulse_led();
        for (int i = 0; i < 4; i++) begin
            expect_frame($sformatf("rx4 ED%0d", i), 8'hED, 1'b1);
            ack_resp($sformatf("rx4 FE%0d", i), 8'hFE);
        end
        repeat (2) @(negedge clk50m);
        chk("rx4 err", int'(err), 1);
        chk("rx4 kb_ready", int'(kb_ready), 0);
        chk("rx4 busy", int'(busy), 0);
        seen = 0;
        repeat (60) begin @(negedge clk50m); if (kbd_clk_oe) seen = 1; end
        chk("rx4 no 5th frame", seen, 0);
        run_reset("rx4 recover");

        // Device never clocks: frame timeout, four attempts, then error
        pulse_led();
        for (int i = 0; i < 4; i++) begin
            dev_frame(1'b0, b, p, s, st, inh, hold);
            chk($sformatf("to%0d inhibit", i), inh, INH);
            chk($sformatf("to%0d hold", i), hold, ACKT);
        end
        wait_idle("to");
        chk("to err", int'(err), 1);
        chk("to kb_ready", int'(kb_ready), 0);
        run_reset("to recover");

        // Frame ACKed but no response byte: response timeout resends
        leds = 3'b110;
        pulse_led();
        expect_frame("rto ED1", 8'hED, 1'b1);
        expect_frame("rto ED2", 8'hED, 1'b1);
        ack_resp("rto FA1", 8'hFA);
        expect_frame("rto val", 8'h06, 1'b1);
        ack_resp("rto FA2", 8'hFA);
        chk("rto err", int'(err), 0);

        // LED request during the BAT wait runs right after 0xAA
        leds = 3'b100;
        pulse_rst();
        expect_frame("pb FF", 8'hFF, 1'b1);
        ack_resp("pb FA", 8'hFA);
        pulse_led();
        chk("pb busy", int'(busy), 1);
        ack_resp("pb AA", 8'hAA);
        expect_frame("pb ED", 8'hED, 1'b1);
        ack_resp("pb FA1", 8'hFA);
        expect_frame("pb val", 8'h04, 1'b0);
        ack_resp("pb FA2", 8'hFA);
        chk("pb kb_ready", int'(kb_ready), 1);

        // Simultaneous reset and LED requests in IDLE
        leds = 3'b001;
        kb_reset_req = 1'b1; led_update = 1'b1;
        @(negedge clk50m);
        kb_reset_req = 1'b0; led_update = 1'b0;
        expect_frame("sim FF", 8'hFF, 1'b1);
        ack_resp("sim FA", 8'hFA);
        ack_resp("sim AA", 8'hAA);
        expect_frame("sim ED", 8'hED, 1'b1);
        ack_resp("sim FA1", 8'hFA);
        expect_frame("sim val", 8'h01, 1'b0);
        ack_resp("sim FA2", 8'hFA);
        chk("sim kb_ready", int'(kb_ready), 1);
        chk("sim err", int'(err), 0);

        // 0xFC in the BAT wait fails and drops the queued LED update
        pulse_rst();
        expect_frame("fc FF", 8'hFF, 1'b1);
        ack_resp("fc FA", 8'hFA);
        pulse_led();
        ack_resp("fc FC", 8'hFC);
        repeat (2) @(negedge clk50m);
        chk("fc err", int'(err), 1);
        chk("fc kb_ready", int'(kb_ready), 0);
        chk("fc busy", int'(busy), 0);
        seen = 0;
        repeat (100) begin @(negedge clk50m); if (kbd_clk_oe) seen = 1; end
        chk("fc led dropped", seen, 0);
        run_reset("fc recover");

        // Async reset in the middle of bit 4 of 0xED (bit 4 is 0 -> data pulled low)
        leds = 3'b000;
        pulse_led();
        seen = 0;
        while (!kbd_clk_oe && seen < 2000) begin @(negedge clk50m); seen++; end
        seen = 0;
        while (kbd_clk_oe && seen < 2000) begin @(negedge clk50m); seen++; end
        repeat (4) @(negedge clk50m);
        for (int i = 0; i < 4; i++) begin
            dev_clk_low = 1'b1; repeat (8) @(negedge clk50m);
            dev_clk_low = 1'b0; repeat (8) @(negedge clk50m);
        end
        dev_clk_low = 1'b1; repeat (6) @(negedge clk50m);
        chk("abort data_oe before", int'(kbd_data_oe), 1);
        reset_n = 1'b0;
        #1;
        chk("abort data_oe", int'(kbd_data_oe), 0);
        chk("abort clk_oe", int'(kbd_clk_oe), 0);
        chk("abort busy", int'(busy), 0);
        @(negedge clk50m);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk50m);
        reset_n = 1'b1;
        expect_frame("abort FF", 8'hFF, 1'b1);
        ack_resp("abort FA", 8'hFA);
        ack_resp("abort AA", 8'hAA);
        chk("abort kb_ready", int'(kb_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
